// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared states and codec register table constants for the I2C config sequencer
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_XFER,
    ST_CHECK,
    ST_GAP,
    ST_FINISH
  } cfg_state_t;

  localparam int unsigned CFG_TABLE_LEN = 10;

  localparam logic [6:0] REG_LLINE_IN     = 7'h00;
  localparam logic [6:0] REG_RLINE_IN     = 7'h01;
  localparam logic [6:0] REG_HEADPHONE    = 7'h02;
  localparam logic [6:0] REG_ANALOG_PATH  = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH = 7'h05;
  localparam logic [6:0] REG_POWER        = 7'h06;
  localparam logic [6:0] REG_IFACE_FMT    = 7'h07;
  localparam logic [6:0] REG_SAMPLE_RATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE       = 7'h09;
  localparam logic [6:0] REG_RESET        = 7'h0F;

  localparam logic [8:0] VAL_RESET        = 9'h000;
  localparam logic [8:0] VAL_LINE_IN      = 9'h017;
  localparam logic [8:0] VAL_HEADPHONE    = 9'h179;
  localparam logic [8:0] VAL_ANALOG_PATH  = 9'h012;
  localparam logic [8:0] VAL_DIGITAL_PATH = 9'h000;
  localparam logic [8:0] VAL_POWER        = 9'h000;
  localparam logic [8:0] VAL_IFACE_FMT    = 9'h042;
  localparam logic [8:0] VAL_SAMPLE_RATE  = 9'h000;
  localparam logic [8:0] VAL_ACTIVE       = 9'h001;

  function automatic logic [15:0] rom_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// rtl/i2c_config_sequencer_if.sv - word/go/end/ack handshake between config sequencer and I2C master
interface i2c_config_sequencer_if;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_ack;

  modport master (output i2c_data, output i2c_go, input i2c_end, input i2c_ack);
  modport slave  (input i2c_data, input i2c_go, output i2c_end, output i2c_ack);
endinterface

// File: rtl/i2c_config_rom.sv
// rtl/i2c_config_rom.sv - combinational codec register table, {reg_addr[6:0], data[8:0]} per entry
module i2c_config_rom
  import i2c_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] word
);

  always_comb begin
    word = '0;
    case (index)
      4'd0:    word = rom_word(REG_RESET,        VAL_RESET);
      4'd1:    word = rom_word(REG_LLINE_IN,     VAL_LINE_IN);
      4'd2:    word = rom_word(REG_RLINE_IN,     VAL_LINE_IN);
      4'd3:    word = rom_word(REG_HEADPHONE,    VAL_HEADPHONE);
      4'd4:    word = rom_word(REG_ANALOG_PATH,  VAL_ANALOG_PATH);
      4'd5:    word = rom_word(REG_DIGITAL_PATH, VAL_DIGITAL_PATH);
      4'd6:    word = rom_word(REG_POWER,        VAL_POWER);
      4'd7:    word = rom_word(REG_IFACE_FMT,    VAL_IFACE_FMT);
      4'd8:    word = rom_word(REG_SAMPLE_RATE,  VAL_SAMPLE_RATE);
      4'd9:    word = rom_word(REG_ACTIVE,       VAL_ACTIVE);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks the codec table through the I2C master; I2C_CFG_TIMEOUT_EN adds a watchdog
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS       = CFG_TABLE_LEN,
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned GAP_CYCLES     = 2700,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  i2c_config_sequencer_if.master  i2c,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [3:0]              reg_index
);

  if (NUM_REGS < 1 || NUM_REGS > 16 || GAP_CYCLES < 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_config_sequencer: parameter out of range");
  end

  cfg_state_t  state;
  logic [15:0] rom_data;
  logic [31:0] retry_cnt;
  logic [31:0] gap_cnt;
  logic        last_acked;
  logic        wd_hit;

`ifdef I2C_CFG_TIMEOUT_EN
  logic [31:0] wd_cnt;
  assign wd_hit = (wd_cnt == TIMEOUT_CYCLES - 1);
`else
  assign wd_hit = 1'b0;
`endif

  i2c_config_rom u_rom (
    .index (reg_index),
    .word  (rom_data)
  );

  // CHECK and LOAD each hold go low one cycle, so GAP spans GAP_CYCLES-2 to keep the low time exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      i2c.i2c_go   <= 1'b0;
      i2c.i2c_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      reg_index    <= '0;
      retry_cnt    <= '0;
      gap_cnt      <= '0;
      last_acked   <= 1'b0;
`ifdef I2C_CFG_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
`ifdef I2C_CFG_TIMEOUT_EN
      if (state == ST_REQ || state == ST_XFER) wd_cnt <= wd_cnt + 32'd1;
      else                                     wd_cnt <= '0;
`endif
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_LOAD;
          busy       <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          reg_index  <= '0;
          retry_cnt  <= '0;
          last_acked <= 1'b0;
        end
        ST_LOAD: begin
          i2c.i2c_data <= {DEV_ADDR, rom_data};
          i2c.i2c_go   <= 1'b1;
          state        <= ST_REQ;
        end
        ST_REQ: begin
          if (wd_hit) begin
            error      <= 1'b1;
            i2c.i2c_go <= 1'b0;
            state      <= ST_FINISH;
          end else if (!i2c.i2c_end) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (wd_hit) begin
            error      <= 1'b1;
            i2c.i2c_go <= 1'b0;
            state      <= ST_FINISH;
          end else if (i2c.i2c_end) begin
            i2c.i2c_go <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          gap_cnt <= '0;
          if (!i2c.i2c_ack) begin
            retry_cnt  <= '0;
            last_acked <= ({28'd0, reg_index} == NUM_REGS - 1);
            if (reg_index != 4'hF) reg_index <= reg_index + 4'd1;
            state      <= ST_GAP;
          end else if (retry_cnt < MAX_RETRIES) begin
            retry_cnt <= retry_cnt + 32'd1;
            state     <= ST_GAP;
          end else begin
            error <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_CYCLES - 3) begin
            if (last_acked) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        ST_FINISH: begin
          busy       <= 1'b0;
          i2c.i2c_go <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - randomized bench for i2c_config_sequencer against a table-walk reference model
module tb_i2c_config_sequencer;

  localparam int unsigned NUM_REGS       = 3;
  localparam logic [7:0]  DEV_ADDR       = 8'h34;
  localparam int unsigned MAX_RETRIES    = 3;
  localparam int unsigned GAP_CYCLES     = 20;
  localparam int unsigned TIMEOUT_CYCLES = 100;
  localparam int          RUN_LIMIT      = 20000;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  idx;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] reg_index;

  i2c_config_sequencer_if sif ();

  i2c_config_sequencer #(
    .NUM_REGS       (NUM_REGS),
    .DEV_ADDR       (DEV_ADDR),
    .MAX_RETRIES    (MAX_RETRIES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i2c       (sif),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .reg_index (reg_index)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_ref [16] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0579, 16'h0812, 16'h0A00, 16'h0C00, 16'h0E42,
                                16'h1000, 16'h1201, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  int   checks = 0;
  int   errors = 0;
  int   nack_plan [16];
  int   nack_left [16];
  int   hang = 0;
  int   data_changes = 0;
  txn_t got_q [$];
  txn_t exp_q [$];
  int   gaps_q [$];
  logic exp_done, exp_err;
  logic [3:0] exp_idx;

  // Master model: optional delay before starting, random transfer length, ack held over the check cycle.
  int          s_phase = 0;
  int          s_cnt = 0;
  logic [23:0] s_data;
  logic        s_nack;
  always @(negedge clk) begin
    if (reset) begin
      s_phase = 0;
      sif.i2c_end = 1'b1;
      sif.i2c_ack = 1'b0;
    end else begin
      case (s_phase)
        0: if (sif.i2c_go && hang == 0) begin
          got_q.push_back({sif.i2c_data, reg_index});
          s_data = sif.i2c_data;
          s_nack = (nack_left[reg_index] > 0);
          if (s_nack) nack_left[reg_index] = nack_left[reg_index] - 1;
          s_cnt = $urandom_range(0, 3);
          s_phase = 1;
        end
        1: begin
          if (sif.i2c_data !== s_data || sif.i2c_go !== 1'b1) data_changes++;
          if (s_cnt == 0) begin
            sif.i2c_end = 1'b0;
            s_cnt = $urandom_range(2, 6);
            s_phase = 2;
          end else s_cnt--;
        end
        2: begin
          if (sif.i2c_data !== s_data || sif.i2c_go !== 1'b1) data_changes++;
          if (s_cnt == 0) begin
            sif.i2c_end = 1'b1;
            sif.i2c_ack = s_nack;
            s_phase = 3;
          end else s_cnt--;
        end
        3: s_phase = 4;
        default: begin
          sif.i2c_ack = 1'b0;
          s_phase = 0;
        end
      endcase
    end
  end

  int mon_low = 0;
  int mon_seen = 0;
  always @(negedge clk) begin
    if (reset) begin
      mon_seen = 0;
      mon_low = 0;
    end else if (sif.i2c_go) begin
      if (mon_seen != 0 && mon_low > 0) gaps_q.push_back(mon_low);
      mon_seen = 1;
      mon_low = 0;
    end else if (mon_seen != 0) begin
      mon_low++;
    end
  end

  task automatic build_expected();
    exp_q.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    exp_idx = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (!exp_err) begin
        int sends;
        sends = (nack_plan[i] > int'(MAX_RETRIES)) ? int'(MAX_RETRIES) + 1 : nack_plan[i] + 1;
        for (int k = 0; k < sends; k++) exp_q.push_back({DEV_ADDR, rom_ref[i], 4'(i)});
        if (nack_plan[i] > int'(MAX_RETRIES)) begin
          exp_err = 1'b1;
          exp_idx = 4'(i);
        end
      end
    end
    if (!exp_err) begin
      exp_done = 1'b1;
      exp_idx = 4'(NUM_REGS);
    end
  endtask

  task automatic clear_run();
    got_q.delete();
    gaps_q.delete();
    data_changes = 0;
    mon_seen = 0;
    hang = 0;
    for (int i = 0; i < 16; i++) nack_left[i] = nack_plan[i];
    build_expected();
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int cyc;
    cyc = 0;
    while (!(busy == 1'b0 && (done == 1'b1 || error == 1'b1)) && cyc < RUN_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= RUN_LIMIT) begin
      errors++;
      $display("FAIL %s finish_wait got no completion within %0d cycles, want done or error", name, RUN_LIMIT);
    end
  endtask

  task automatic check_run(input string name);
    int n;
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s txn_count got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s txn[%0d] got data=%h idx=%0d want data=%h idx=%0d", name, i,
                 got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
    checks++;
    if (done !== exp_done || error !== exp_err || reg_index !== exp_idx || busy !== 1'b0 || sif.i2c_go !== 1'b0) begin
      errors++;
      $display("FAIL %s final got done=%b error=%b idx=%0d busy=%b go=%b want done=%b error=%b idx=%0d busy=0 go=0",
               name, done, error, reg_index, busy, sif.i2c_go, exp_done, exp_err, exp_idx);
    end
    checks++;
    if (gaps_q.size() != ((exp_q.size() > 0) ? exp_q.size() - 1 : 0)) begin
      errors++;
      $display("FAIL %s gap_count got %0d want %0d", name, gaps_q.size(), exp_q.size() - 1);
    end
    foreach (gaps_q[i]) begin
      checks++;
      if (gaps_q[i] != int'(GAP_CYCLES)) begin
        errors++;
        $display("FAIL %s gap[%0d] got %0d want %0d", name, i, gaps_q[i], GAP_CYCLES);
      end
    end
    checks++;
    if (data_changes != 0) begin
      errors++;
      $display("FAIL %s data_stable got %0d changes want 0", name, data_changes);
    end
  endtask

  task automatic run_seq(input string name);
    clear_run();
    launch();
    wait_finish(name);
    check_run(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sif.i2c_go !== 1'b0 || sif.i2c_data !== 24'h0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || reg_index !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got go=%b data=%h busy=%b done=%b error=%b idx=%0d want all zero",
               sif.i2c_go, sif.i2c_data, busy, done, error, reg_index);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    clear_run();
    launch();
    checks++;
    if (sif.i2c_go !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_1 got go=%b busy=%b want go=0 busy=1", sif.i2c_go, busy);
    end
    @(negedge clk);
    checks++;
    if (sif.i2c_go !== 1'b1 || sif.i2c_data !== 24'h341E00) begin
      errors++;
      $display("FAIL latency_2 got go=%b data=%h want go=1 data=341e00", sif.i2c_go, sif.i2c_data);
    end
    wait_finish("nominal");
    check_run("nominal");
  endtask

  task automatic test_single_nack();
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    nack_plan[1] = 1;
    run_seq("single_nack");
  endtask

  task automatic test_retry_exhaust();
    int sz;
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    nack_plan[2] = 99;
    run_seq("retry_exhaust");
    sz = got_q.size();
    repeat (50) @(negedge clk);
    checks++;
    if (got_q.size() != sz || sif.i2c_go !== 1'b0) begin
      errors++;
      $display("FAIL retry_exhaust_quiet got txns=%0d go=%b want txns=%0d go=0", got_q.size(), sif.i2c_go, sz);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int target;
    int cyc;
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    clear_run();
    target = $urandom_range(1, NUM_REGS);
    launch();
    cyc = 0;
    while (!(got_q.size() == target && sif.i2c_end === 1'b0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL mid_xfer_reach got no transfer %0d in progress want one", target);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sif.i2c_go !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || reg_index !== 4'd0) begin
      errors++;
      $display("FAIL mid_xfer_reset got go=%b busy=%b done=%b error=%b idx=%0d want all zero",
               sif.i2c_go, busy, done, error, reg_index);
    end
    @(negedge clk);
    reset = 1'b0;
    run_seq("restart_after_reset");
  endtask

  task automatic test_start_while_busy();
    int cyc;
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    clear_run();
    launch();
    cyc = 0;
    while (!(got_q.size() == 1 && s_phase == 0 && sif.i2c_go === 1'b0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish("start_in_gap");
    check_run("start_in_gap");
    clear_run();
    launch();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_clears_done got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    wait_finish("rerun");
    check_run("rerun");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) nack_plan[i] = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) nack_plan[$urandom_range(0, NUM_REGS - 1)] = 4;
      run_seq($sformatf("random_%0d", r));
    end
  endtask

`ifdef I2C_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int go_cnt;
    int cyc;
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    clear_run();
    hang = 1;
    launch();
    go_cnt = 0;
    cyc = 0;
    while (error !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      if (sif.i2c_go === 1'b1) go_cnt++;
      cyc++;
    end
    checks++;
    if (error !== 1'b1 || sif.i2c_go !== 1'b0 || reg_index !== 4'd0 || done !== 1'b0 || go_cnt != int'(TIMEOUT_CYCLES)) begin
      errors++;
      $display("FAIL timeout got error=%b go=%b idx=%0d done=%b go_cycles=%0d want error=1 go=0 idx=0 done=0 go_cycles=%0d",
               error, sif.i2c_go, reg_index, done, go_cnt, TIMEOUT_CYCLES);
    end
    repeat (3) @(negedge clk);
    hang = 0;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL global_time_limit got no end want summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    test_reset();
    test_nominal();
    test_single_nack();
    test_retry_exhaust();
    test_reset_mid_xfer();
    test_start_while_busy();
    test_random();
`ifdef I2C_CFG_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Upstream stage of the I2C master; walks a fixed table of codec register writes after reset/start.
- Each entry is presented to the master as a 24-bit word: {DEV_ADDR, reg_word[15:0]}.
- Runs the go/transmission_end handshake for each entry, retries NACKed writes and reports completion or error to the top level (audio codec bring-up).

Parameters:
- NUM_REGS, 10, number of table entries sent (1..16).
- DEV_ADDR, 8'h34, 8-bit device write address placed in data[23:16].
- MAX_RETRIES, 3, re-sends allowed per entry after a NACK before error.
- GAP_CYCLES, 2700, clk cycles go is held low between transactions (100 us at 27 MHz).
- TIMEOUT_CYCLES, 2700000, watchdog limit per transaction (only with the optional feature).

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sequence when idle.
- i2c_data  out  24  word to transmit; stable while i2c_go=1.
- i2c_go  out  1  transaction request to master.
- i2c_end  in  1  master transmission_end; 1 = idle/finished, 0 = transfer in progress.
- i2c_ack  in  1  master ack; 1 = NACK seen on any ack slot.
- busy  out  1  sequence in progress.
- done  out  1  sticky; all NUM_REGS entries acknowledged.
- error  out  1  sticky; an entry exhausted retries or timed out.
- reg_index  out  4  entry currently being sent / failing entry.

Behaviour:
- Reset (any state, mid-transfer included): state IDLE, i2c_go=0, i2c_data=0, busy=0, done=0, error=0, reg_index=0, retry and gap counters 0. Master is expected to abort on its own reset.
- States: IDLE, LOAD, REQ, XFER, CHECK, GAP, FINISH.
- IDLE: start=1 -> LOAD, busy=1, done=0, error=0, reg_index=0. start ignored in any other state.
- LOAD (1 cycle): i2c_data <= {DEV_ADDR, rom(reg_index)}; -> REQ.
- REQ: i2c_go=1; wait for i2c_end=0 (master started) -> XFER.
- XFER: i2c_go stays 1; wait for i2c_end=1 -> CHECK. i2c_data must not change during REQ/XFER.
- CHECK (1 cycle): sample i2c_ack.
  - 0 (ACK): retry count <= 0; reg_index+1.
  - 1 (NACK) with retry count < MAX_RETRIES: retry count+1; reg_index kept.
  - 1 (NACK) with retry count = MAX_RETRIES: error=1 -> FINISH.
- GAP: i2c_go=0 for exactly GAP_CYCLES cycles. Then reg_index = NUM_REGS -> done=1 -> FINISH; otherwise -> LOAD.
- FINISH: busy=0, i2c_go=0 -> IDLE (one cycle); done/error held until the next start or reset.
- reg_index is 4 bits and never wraps: the comparison with NUM_REGS happens before LOAD.
- Latency: start to i2c_go rising = 2 cycles (IDLE->LOAD->REQ).
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro I2C_CFG_TIMEOUT_EN.
- Defined: a counter runs in REQ and XFER. Reaching TIMEOUT_CYCLES sets error=1, i2c_go=0 -> FINISH, with reg_index holding the stuck entry.
- Undefined: no counter; REQ/XFER wait indefinitely. TIMEOUT_CYCLES unused.

Decomposition:
- Shared package i2c_cfg_pkg: state encoding constants; codec register constants (reset, line-in, headphone, analog path, digital path, power, interface format, sample rate, active); table length.
- One sub-module, i2c_config_rom: combinational 4-bit index -> 16-bit {reg_addr[6:0], data[8:0]} lookup; out-of-range returns 16'h0000.

Test Plan:
- Nominal: NUM_REGS=3, master model ACKs all -> three go pulses with i2c_data 24'h34_1E00, then entries 1 and 2; done=1, error=0, busy=0; go low exactly GAP_CYCLES between pulses.
- Single NACK: model NACKs entry 1 once -> entry 1 sent twice with identical i2c_data, reg_index=1 during both, then sequence completes with done=1.
- Retry exhaustion: MAX_RETRIES=3, entry 2 always NACK -> 4 transactions for entry 2, error=1, done=0, reg_index=2, no further go.
- Reset mid-XFER: assert reset while i2c_end=0 -> next cycle i2c_go=0, busy=0, done=0, reg_index=0; a following start restarts from entry 0.
- Start while busy: pulse start during GAP of entry 0 -> ignored, sequence order unchanged; a start after done clears done and reruns.
- Timeout (I2C_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=100): model never drops i2c_end -> error=1 after 100 cycles in REQ, i2c_go=0, reg_index=0.
